// File: rtl/gtech_evt_pkg.sv
// Shared constants, FSM state type and helpers for the 8-channel event pending block.
package gtech_evt_pkg;

  localparam int unsigned NCH   = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } evt_state_e;

  // One-hot decode of a channel index.
  function automatic logic [NCH-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NCH-1:0] one;
    one = {{(NCH-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/gtech_rr_pick8.sv
// Combinational round-robin picker: first request at or after ptr, wrapping modulo 8.
module gtech_rr_pick8
  import gtech_evt_pkg::*;
(
  input  logic [NCH-1:0]   req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] pos;
  logic             hit;

  // Scan ptr, ptr+1, ... ptr+7; the 3-bit add wraps naturally.
  always_comb begin
    hit   = 1'b0;
    idx_o = '0;
    pos   = ptr_i;
    for (int unsigned k = 0; k < NCH; k++) begin
      pos = ptr_i + IDX_W'(k);
      if (!hit && req_i[pos]) begin
        hit   = 1'b1;
        idx_o = pos;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/gtech_evt_pend8.sv
// Eight-channel event pending register with sticky overflow and a round-robin
// valid/ready service handshake. PEND feeds the downstream 8-input OR cell.
module gtech_evt_pend8
  import gtech_evt_pkg::*;
#(
  parameter bit EDGE = 1'b1  // 1: rising edges of EV are events, 0: EV levels
) (
  input  logic             CP,
  input  logic             RST,
  input  logic [NCH-1:0]   EV,
  input  logic [NCH-1:0]   MASK,
  output logic [NCH-1:0]   PEND,
  output logic             SEL_VALID,
  output logic [IDX_W-1:0] SEL_IDX,
  input  logic             SEL_READY,
  output logic [NCH-1:0]   OVF,
  input  logic [NCH-1:0]   OVF_CLR
);

  evt_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] sel_idx_q;
  logic [NCH-1:0]   ev_d_q;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   ovf_q, ovf_d;

  logic [NCH-1:0]   ev;
  logic [NCH-1:0]   clr;
  logic [NCH-1:0]   cand;
  logic             xfer;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  // Event detection; ev_d resets to 0 so an input high at release is an event.
  always_comb begin
    if (EDGE) ev = EV & ~ev_d_q;
    else      ev = EV;
  end

  // Transfer and the resulting per-channel clear.
  always_comb begin
    xfer = (state_q == ST_OFFER) && SEL_READY;
    clr  = xfer ? idx_onehot(sel_idx_q) : '0;
  end

  // Next pending/overflow state: set wins over clear in both cases, and an
  // event that lands on the channel being drained is not an overflow.
  always_comb begin
    pend_d = (pend_q & ~clr) | ev;
    ovf_d  = (ovf_q & ~OVF_CLR) | (ev & pend_q & ~clr);
  end

  assign cand = pend_q & MASK;

  gtech_rr_pick8 u_pick (
    .req_i   (cand),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Event, pending and overflow registers.
  always_ff @(posedge CP) begin
    if (RST) begin
      ev_d_q <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      ev_d_q <= EV;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // Offer FSM; the offered index is latched in IDLE and held until accepted,
  // regardless of later MASK changes.
  always_ff @(posedge CP) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      sel_idx_q <= '0;
      ptr_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            sel_idx_q <= pick_idx;
            state_q   <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (SEL_READY) begin
            ptr_q   <= sel_idx_q + IDX_W'(1);
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PEND      = pend_q & MASK;
  assign SEL_VALID = (state_q == ST_OFFER);
  assign SEL_IDX   = sel_idx_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_gtech_evt_pend8.sv
// Scoreboard bench for gtech_evt_pend8: expected transfer indices are queued by
// the stimulus and popped by a monitor on each valid&ready cycle.
module tb_gtech_evt_pend8;

  logic       CP;
  logic       RST;
  logic [7:0] EV;
  logic [7:0] MASK;
  logic [7:0] PEND;
  logic       SEL_VALID;
  logic [2:0] SEL_IDX;
  logic       SEL_READY;
  logic [7:0] OVF;
  logic [7:0] OVF_CLR;

  logic [7:0] pk_req;
  logic [2:0] pk_ptr;
  logic       pk_found;
  logic [2:0] pk_idx;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  gtech_evt_pend8 #(.EDGE(1'b1)) dut (
    .CP        (CP),
    .RST       (RST),
    .EV        (EV),
    .MASK      (MASK),
    .PEND      (PEND),
    .SEL_VALID (SEL_VALID),
    .SEL_IDX   (SEL_IDX),
    .SEL_READY (SEL_READY),
    .OVF       (OVF),
    .OVF_CLR   (OVF_CLR)
  );

  gtech_rr_pick8 u_pick_ut (
    .req_i   (pk_req),
    .ptr_i   (pk_ptr),
    .found_o (pk_found),
    .idx_o   (pk_idx)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Monitor: a transfer happens at the next rising edge when valid&ready now.
  always @(negedge CP) begin
    if (RST === 1'b0 && SEL_VALID === 1'b1 && SEL_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL xfer_unexpected got=%0d exp=none", SEL_IDX);
      end else begin
        chk("xfer_idx", {29'd0, SEL_IDX}, exp_q.pop_front());
      end
    end
  end

  // Picker unit vectors: {req, ptr, found, idx}
  logic [7:0] pv_req [9] = '{8'h00, 8'h81, 8'h81, 8'h81, 8'h01, 8'h10, 8'hFF, 8'h24, 8'h24};
  logic [2:0] pv_ptr [9] = '{3'd3,  3'd0,  3'd1,  3'd7,  3'd5,  3'd4,  3'd6,  3'd3,  3'd6};
  logic       pv_fnd [9] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1};
  logic [2:0] pv_idx [9] = '{3'd0,  3'd0,  3'd7,  3'd7,  3'd0,  3'd4,  3'd6,  3'd5,  3'd2};

  initial begin
    RST = 1'b1; EV = '0; MASK = 8'hFF; SEL_READY = 1'b0; OVF_CLR = '0;
    pk_req = '0; pk_ptr = '0;

    for (int i = 0; i < 9; i++) begin
      pk_req = pv_req[i];
      pk_ptr = pv_ptr[i];
      #1;
      chk("pick_found", {31'd0, pk_found}, {31'd0, pv_fnd[i]});
      if (pv_fnd[i]) chk("pick_idx", {29'd0, pk_idx}, {29'd0, pv_idx[i]});
    end

    // Idle after reset, then a single event on channel 3.
    do_reset();
    chk("rst_ovf", {24'd0, OVF}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_pend", {24'd0, PEND}, 32'h0);
      chk("idle_valid", {31'd0, SEL_VALID}, 32'h0);
    end
    EV = 8'h08;
    tick();
    EV = 8'h00;
    chk("ev3_pend", {24'd0, PEND}, 32'h08);
    chk("ev3_valid_n", {31'd0, SEL_VALID}, 32'h0);
    tick();
    chk("ev3_valid", {31'd0, SEL_VALID}, 32'h1);
    chk("ev3_idx", {29'd0, SEL_IDX}, 32'd3);
    exp_q.push_back(3);
    SEL_READY = 1'b1;
    tick();
    SEL_READY = 1'b0;
    chk("ev3_pend_clr", {24'd0, PEND}, 32'h0);
    chk("ev3_valid_drop", {31'd0, SEL_VALID}, 32'h0);

    // Channels 0 and 7 together: 0, 7, then 0, 7 again (ptr wraps), 1-cycle gaps.
    do_reset();
    SEL_READY = 1'b1;
    for (int r = 0; r < 2; r++) begin
      EV = 8'h81;
      tick();
      EV = 8'h00;
      chk("rr_pend", {24'd0, PEND}, 32'h81);
      exp_q.push_back(0);
      exp_q.push_back(7);
      tick();
      chk("rr_v1", {31'd0, SEL_VALID}, 32'h1);
      chk("rr_idx0", {29'd0, SEL_IDX}, 32'd0);
      tick();
      chk("rr_gap1", {31'd0, SEL_VALID}, 32'h0);
      tick();
      chk("rr_v2", {31'd0, SEL_VALID}, 32'h1);
      chk("rr_idx7", {29'd0, SEL_IDX}, 32'd7);
      tick();
      chk("rr_gap2", {31'd0, SEL_VALID}, 32'h0);
      chk("rr_pend_empty", {24'd0, PEND}, 32'h0);
    end
    SEL_READY = 1'b0;

    // Overflow on channel 5, clear, and set-wins-over-clear.
    EV = 8'h20;
    tick();
    EV = 8'h00;
    tick();
    chk("ovf_offer5", {29'd0, SEL_IDX}, 32'd5);
    chk("ovf_none", {24'd0, OVF}, 32'h0);
    EV = 8'h20;
    tick();
    EV = 8'h00;
    chk("ovf_set", {24'd0, OVF}, 32'h20);
    OVF_CLR = 8'h20;
    tick();
    OVF_CLR = 8'h00;
    chk("ovf_clr", {24'd0, OVF}, 32'h0);
    EV = 8'h20;
    OVF_CLR = 8'h20;
    tick();
    EV = 8'h00;
    OVF_CLR = 8'h00;
    chk("ovf_set_wins", {24'd0, OVF}, 32'h20);
    tick();
    chk("ovf_sticky", {24'd0, OVF}, 32'h20);
    exp_q.push_back(5);
    SEL_READY = 1'b1;
    tick();
    SEL_READY = 1'b0;
    chk("ovf_drain", {24'd0, PEND}, 32'h0);

    // Masking the offered channel does not retract the offer.
    do_reset();
    EV = 8'h04;
    tick();
    EV = 8'h00;
    tick();
    chk("mask_offer_idx", {29'd0, SEL_IDX}, 32'd2);
    MASK = 8'hFB;
    #1;
    chk("mask_pend_comb", {24'd0, PEND}, 32'h0);
    tick();
    chk("mask_valid_held", {31'd0, SEL_VALID}, 32'h1);
    chk("mask_idx_held", {29'd0, SEL_IDX}, 32'd2);
    chk("mask_pend", {24'd0, PEND}, 32'h0);
    exp_q.push_back(2);
    SEL_READY = 1'b1;
    tick();
    SEL_READY = 1'b0;
    chk("mask_valid_drop", {31'd0, SEL_VALID}, 32'h0);
    MASK = 8'hFF;
    #1;
    chk("mask_pend_cleared", {24'd0, PEND}, 32'h0);

    // Event on channel 4 in the same cycle as its transfer.
    do_reset();
    EV = 8'h10;
    tick();
    EV = 8'h00;
    tick();
    chk("same_offer4", {29'd0, SEL_IDX}, 32'd4);
    EV = 8'h10;
    SEL_READY = 1'b1;
    exp_q.push_back(4);
    tick();
    EV = 8'h00;
    SEL_READY = 1'b0;
    chk("same_pend", {24'd0, PEND}, 32'h10);
    chk("same_ovf", {24'd0, OVF}, 32'h0);
    chk("same_gap", {31'd0, SEL_VALID}, 32'h0);
    tick();
    chk("same_reoffer_v", {31'd0, SEL_VALID}, 32'h1);
    chk("same_reoffer_idx", {29'd0, SEL_IDX}, 32'd4);
    exp_q.push_back(4);
    SEL_READY = 1'b1;
    tick();
    SEL_READY = 1'b0;
    chk("same_drain", {24'd0, PEND}, 32'h0);

    // Reset mid-offer (ptr is 5 here, so the offer is of channel 5).
    EV = 8'hFF;
    tick();
    EV = 8'h00;
    chk("rst_pend_ff", {24'd0, PEND}, 32'hFF);
    tick();
    chk("rst_offer_v", {31'd0, SEL_VALID}, 32'h1);
    chk("rst_offer_idx", {29'd0, SEL_IDX}, 32'd5);
    EV = 8'h01;
    tick();
    EV = 8'h00;
    chk("rst_pre_ovf", {24'd0, OVF}, 32'h01);
    RST = 1'b1;
    tick();
    chk("rst_pend", {24'd0, PEND}, 32'h0);
    chk("rst_valid", {31'd0, SEL_VALID}, 32'h0);
    chk("rst_idx", {29'd0, SEL_IDX}, 32'd0);
    chk("rst_ovf_clr", {24'd0, OVF}, 32'h0);

    // EV held high through reset: exactly one event captured after release.
    EV = 8'hFF;
    tick();
    RST = 1'b0;
    tick();
    chk("hold_pend", {24'd0, PEND}, 32'hFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_ovf", {24'd0, OVF}, 32'h0);
      chk("hold_pend_keep", {24'd0, PEND}, 32'hFF);
    end
    EV = 8'h00;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
